// File: rtl/shift_reg_sequencer_pkg.sv
// Shared types and encodings for the shift-register command sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    CAPTURE
  } state_e;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/shift_reg_sequencer_if.sv
// Command/response bundle between the two requesters and the sequencer.
// master: requester side (drives commands), slave: sequencer side.
interface shift_reg_sequencer_if #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 3
);

  logic             a_valid;
  logic             a_ready;
  logic [W-1:0]     a_data;
  logic [CNT_W-1:0] a_cnt;
  logic             a_dir;

  logic             b_valid;
  logic             b_ready;
  logic [W-1:0]     b_data;
  logic [CNT_W-1:0] b_cnt;
  logic             b_dir;

  logic             rsp_valid;
  logic             rsp_id;
  logic [W-1:0]     rsp_data;

  modport master (
    output a_valid, a_data, a_cnt, a_dir,
    output b_valid, b_data, b_cnt, b_dir,
    input  a_ready, b_ready,
    input  rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  a_valid, a_data, a_cnt, a_dir,
    input  b_valid, b_data, b_cnt, b_dir,
    output a_ready, b_ready,
    output rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/shift_reg_sequencer_rr_arb2.sv
// Two-way round-robin arbiter. Grants are combinational and double as the
// accept strobe; the pointer moves to the other requester on every accept.
module rr_arb2
  import shift_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic en,
  output logic gnt_a,
  output logic gnt_b
);

  logic ptr_q;

  // Single requester wins outright; a tie goes to the pointer.
  always_comb begin
    gnt_a = en & req_a & (~req_b | (ptr_q == REQ_A));
    gnt_b = en & req_b & (~req_a | (ptr_q == REQ_B));
  end

  // Pointer favours whoever was not just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= REQ_A;
    end else if (gnt_a) begin
      ptr_q <= REQ_B;
    end else if (gnt_b) begin
      ptr_q <= REQ_A;
    end
  end

endmodule

// File: rtl/shift_reg_sequencer.sv
// Two-port command sequencer driving one shared W-bit load/shift register.
// Each command loads a word, shifts it n times (n clamped to W) at one step
// per DIV clocks, then returns the register contents as a tagged response.
// Optional: define STAT_CNT_EN to add a saturating op_count[15:0] output.
module shift_reg_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 3,
  parameter int unsigned DIV   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_reg_sequencer_if.slave  bus,
  output logic                  sr_load,
  output logic                  sr_shift,
  output logic                  sr_dir,
  output logic [W-1:0]          sr_data_in,
  input  logic [W-1:0]          sr_data_out,
`ifdef STAT_CNT_EN
  output logic [15:0]           op_count,
`endif
  output logic                  busy
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  state_e           state_q;
  logic [CNT_W-1:0] rem_q;
  logic [PW-1:0]    presc_q;
  logic             id_q;

  logic             sr_load_q;
  logic             sr_shift_q;
  logic             sr_dir_q;
  logic [W-1:0]     sr_data_in_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [W-1:0]     rsp_data_q;
  logic             busy_q;

  logic             idle;
  logic             gnt_a;
  logic             gnt_b;
  logic             accept;
  logic [W-1:0]     cmd_data;
  logic [CNT_W-1:0] cmd_cnt;
  logic             cmd_dir;
  logic             cmd_id;

  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] c);
    if (32'(c) > W) begin
      return CNT_W'(W);
    end
    return c;
  endfunction

  assign idle = (state_q == IDLE);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_a (bus.a_valid),
    .req_b (bus.b_valid),
    .en    (idle),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  // Grant already implies valid, so ready&valid reduces to the grant.
  assign bus.a_ready = gnt_a;
  assign bus.b_ready = gnt_b;
  assign accept      = gnt_a | gnt_b;

  // Select the granted requester's command fields.
  always_comb begin
    cmd_data = bus.a_data;
    cmd_cnt  = bus.a_cnt;
    cmd_dir  = bus.a_dir;
    cmd_id   = REQ_A;
    if (gnt_b) begin
      cmd_data = bus.b_data;
      cmd_cnt  = bus.b_cnt;
      cmd_dir  = bus.b_dir;
      cmd_id   = REQ_B;
    end
  end

  // Sequencer FSM; outputs are registered for the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      presc_q      <= '0;
      id_q         <= REQ_A;
      sr_load_q    <= 1'b0;
      sr_shift_q   <= 1'b0;
      sr_dir_q     <= 1'b0;
      sr_data_in_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q      <= LOAD;
            busy_q       <= 1'b1;
            sr_load_q    <= 1'b1;
            sr_data_in_q <= cmd_data;
            sr_dir_q     <= cmd_dir;
            rem_q        <= clamp_cnt(cmd_cnt);
            id_q         <= cmd_id;
          end
        end
        LOAD: begin
          sr_load_q    <= 1'b0;
          sr_data_in_q <= '0;
          presc_q      <= '0;
          if (rem_q == '0) begin
            state_q  <= CAPTURE;
            sr_dir_q <= 1'b0;
          end else begin
            state_q    <= SHIFT;
            sr_shift_q <= (PRESC_LAST == '0);
          end
        end
        SHIFT: begin
          if (presc_q == PRESC_LAST) begin
            // A shift step is issued this cycle.
            presc_q <= '0;
            rem_q   <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_q    <= CAPTURE;
              sr_shift_q <= 1'b0;
              sr_dir_q   <= 1'b0;
            end else begin
              sr_shift_q <= (PRESC_LAST == '0);
            end
          end else begin
            presc_q    <= presc_q + PW'(1);
            sr_shift_q <= ((presc_q + PW'(1)) == PRESC_LAST);
          end
        end
        CAPTURE: begin
          // Register has settled after the final step; return it.
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= sr_data_out;
          rsp_id_q    <= id_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef STAT_CNT_EN
  logic [15:0] op_count_q;

  // Count completed responses, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= '0;
    end else if (rsp_valid_q && (op_count_q != 16'hFFFF)) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`endif

  assign sr_load       = sr_load_q;
  assign sr_shift      = sr_shift_q;
  assign sr_dir        = sr_dir_q;
  assign sr_data_in    = sr_data_in_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Bench for shift_reg_sequencer: two instances (DIV=1 and DIV=3), each with a
// behavioural shift register and a response scoreboard.
module tb_shift_reg_sequencer;
  import shift_seq_pkg::*;

  localparam int W     = 4;
  localparam int CNT_W = 3;

  typedef struct {
    logic         id;
    logic [W-1:0] ld;
    logic [W-1:0] data;
    logic         dir;
    int           n;
    int           acc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [CNT_W-1:0] c,
                                         input logic dir);
    int n;
    logic [W-1:0] r;
    n = (int'(c) > W) ? W : int'(c);
    r = d;
    for (int i = 0; i < n; i++) begin
      r = (dir == DIR_LEFT) ? {r[W-2:0], 1'b0} : {1'b0, r[W-1:1]};
    end
    return r;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int DIVG = (gi == 0) ? 1 : 3;

    shift_reg_sequencer_if #(.W(W), .CNT_W(CNT_W)) bus ();

    logic         sr_load;
    logic         sr_shift;
    logic         sr_dir;
    logic [W-1:0] sr_data_in;
    logic [W-1:0] sr_q;
    logic         busy;
`ifdef STAT_CNT_EN
    logic [15:0]  op_count;
`endif

    shift_reg_sequencer #(.W(W), .CNT_W(CNT_W), .DIV(DIVG)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .sr_load     (sr_load),
      .sr_shift    (sr_shift),
      .sr_dir      (sr_dir),
      .sr_data_in  (sr_data_in),
      .sr_data_out (sr_q),
`ifdef STAT_CNT_EN
      .op_count    (op_count),
`endif
      .busy        (busy)
    );

    // Controlled shift register, sharing the sequencer reset.
    always @(posedge clk or posedge rst) begin
      if (rst) sr_q <= '0;
      else if (sr_load) sr_q <= sr_data_in;
      else if (sr_shift) sr_q <= sr_dir ? {sr_q[W-2:0], 1'b0} : {1'b0, sr_q[W-1:1]};
    end

    exp_t exp_q[$];
    int   shifts;
    int   busy_cyc;
    int   last_pulse;

    // Scoreboard: push on handshake, pop and compare on response.
    always @(negedge clk) begin
      exp_t e;
      if (rst) begin
        exp_q.delete();
        shifts   = 0;
        busy_cyc = 0;
      end else begin
        if (bus.rsp_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'(bus.rsp_valid), 32'(0));
          end else begin
            e = exp_q.pop_front();
            check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
            check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
            check("latency", 32'(cyc - e.acc), 32'(2 + e.n * DIVG));
            check("shift_pulses", 32'(shifts), 32'(e.n));
            check("busy_cycles", 32'(busy_cyc), 32'(2 + e.n * DIVG));
          end
        end
        if ((bus.a_valid && bus.a_ready) || (bus.b_valid && bus.b_ready)) begin
          check("one_ready", 32'(bus.a_ready & bus.b_ready), 32'(0));
          e.id   = bus.b_ready ? REQ_B : REQ_A;
          e.ld   = bus.b_ready ? bus.b_data : bus.a_data;
          e.dir  = bus.b_ready ? bus.b_dir : bus.a_dir;
          e.data = bus.b_ready ? model(bus.b_data, bus.b_cnt, bus.b_dir)
                               : model(bus.a_data, bus.a_cnt, bus.a_dir);
          e.n    = bus.b_ready ? ((int'(bus.b_cnt) > W) ? W : int'(bus.b_cnt))
                               : ((int'(bus.a_cnt) > W) ? W : int'(bus.a_cnt));
          e.acc  = cyc + 1;
          exp_q.push_back(e);
          shifts   = 0;
          busy_cyc = 0;
        end
        if (busy) busy_cyc++;
        if (sr_load && exp_q.size() > 0) begin
          check("load_data", 32'(sr_data_in), 32'(exp_q[0].ld));
        end
        if (sr_shift) begin
          check("load_shift_excl", 32'(sr_load), 32'(0));
          if (exp_q.size() > 0) check("shift_dir", 32'(sr_dir), 32'(exp_q[0].dir));
          if (shifts > 0) check("shift_spacing", 32'(cyc - last_pulse), 32'(DIVG));
          last_pulse = cyc;
          shifts++;
        end
      end
    end
  end

  // Waits for either ready on DUT0 at a negedge; both low on timeout.
  task automatic wait_any0(output logic ra, output logic rb);
    ra = 1'b0;
    rb = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (g_dut[0].bus.a_ready || g_dut[0].bus.b_ready) begin
        ra = g_dut[0].bus.a_ready;
        rb = g_dut[0].bus.b_ready;
        break;
      end
    end
  endtask

  task automatic send0(input logic port_b, input logic [W-1:0] d, input logic [CNT_W-1:0] c,
                       input logic dir);
    logic ra, rb;
    @(posedge clk); #1;
    if (port_b) begin
      g_dut[0].bus.b_data = d; g_dut[0].bus.b_cnt = c; g_dut[0].bus.b_dir = dir;
      g_dut[0].bus.b_valid = 1'b1;
    end else begin
      g_dut[0].bus.a_data = d; g_dut[0].bus.a_cnt = c; g_dut[0].bus.a_dir = dir;
      g_dut[0].bus.a_valid = 1'b1;
    end
    wait_any0(ra, rb);
    check(port_b ? "accept_b" : "accept_a", 32'(port_b ? rb : ra), 32'(1));
    @(posedge clk); #1;
    g_dut[0].bus.a_valid = 1'b0;
    g_dut[0].bus.b_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (g_dut[0].exp_q.size() == 0 && g_dut[1].exp_q.size() == 0 &&
          !g_dut[0].busy && !g_dut[1].busy) break;
    end
    check("drain", 32'(g_dut[0].exp_q.size() + g_dut[1].exp_q.size()), 32'(0));
  endtask

  initial begin
    logic ra, rb;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst      = 1'b0;
    g_dut[0].bus.a_valid = 1'b0; g_dut[0].bus.a_data = '0; g_dut[0].bus.a_cnt = '0;
    g_dut[0].bus.a_dir = 1'b0;
    g_dut[0].bus.b_valid = 1'b0; g_dut[0].bus.b_data = '0; g_dut[0].bus.b_cnt = '0;
    g_dut[0].bus.b_dir = 1'b0;
    g_dut[1].bus.a_valid = 1'b0; g_dut[1].bus.a_data = '0; g_dut[1].bus.a_cnt = '0;
    g_dut[1].bus.a_dir = 1'b0;
    g_dut[1].bus.b_valid = 1'b0; g_dut[1].bus.b_data = '0; g_dut[1].bus.b_cnt = '0;
    g_dut[1].bus.b_dir = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_busy", 32'(g_dut[0].busy), 32'(0));
    check("rst_rsp_valid", 32'(g_dut[0].bus.rsp_valid), 32'(0));
    check("rst_sr_ctl", 32'({g_dut[0].sr_load, g_dut[0].sr_shift, g_dut[0].sr_dir}), 32'(0));
    check("rst_busy_div3", 32'(g_dut[1].busy), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single commands on each port.
    send0(1'b0, 4'b1011, 3'd1, DIR_LEFT);
    drain();
    send0(1'b1, 4'b1011, 3'd2, DIR_RIGHT);
    drain();

    // Tie after fresh pointer; A re-asserts but B must win the next grant.
    @(posedge clk); #1;
    g_dut[0].bus.a_data = 4'b0001; g_dut[0].bus.a_cnt = 3'd0; g_dut[0].bus.a_dir = 1'b0;
    g_dut[0].bus.b_data = 4'b1000; g_dut[0].bus.b_cnt = 3'd0; g_dut[0].bus.b_dir = 1'b0;
    g_dut[0].bus.a_valid = 1'b1;
    g_dut[0].bus.b_valid = 1'b1;
    wait_any0(ra, rb);
    check("tie_first_a", 32'({ra, rb}), 32'(2'b10));
    @(posedge clk); #1;
    g_dut[0].bus.a_data = 4'b0101;
    wait_any0(ra, rb);
    check("tie_second_b", 32'({ra, rb}), 32'(2'b01));
    @(posedge clk); #1;
    g_dut[0].bus.b_valid = 1'b0;
    wait_any0(ra, rb);
    check("tie_third_a", 32'({ra, rb}), 32'(2'b10));
    @(posedge clk); #1;
    g_dut[0].bus.a_valid = 1'b0;
    drain();

    // Count above W is clamped.
    send0(1'b0, 4'b1111, 3'd7, DIR_LEFT);
    drain();

    // Prescaled instance.
    @(posedge clk); #1;
    g_dut[1].bus.a_data = 4'b1011; g_dut[1].bus.a_cnt = 3'd2; g_dut[1].bus.a_dir = DIR_LEFT;
    g_dut[1].bus.a_valid = 1'b1;
    ra = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (g_dut[1].bus.a_ready) begin ra = 1'b1; break; end
    end
    check("accept_div3", 32'(ra), 32'(1));
    @(posedge clk); #1;
    g_dut[1].bus.a_valid = 1'b0;
    drain();

    // Reset in the middle of a shift sequence (pointer currently on B).
    send0(1'b0, 4'b1111, 3'd4, DIR_RIGHT);
    @(posedge clk);
    @(posedge clk); #2;
    check("pre_rst_busy", 32'(g_dut[0].busy), 32'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(g_dut[0].busy), 32'(0));
    check("mid_rst_sr_ctl", 32'({g_dut[0].sr_load, g_dut[0].sr_shift, g_dut[0].sr_dir}), 32'(0));
    check("mid_rst_data_in", 32'(g_dut[0].sr_data_in), 32'(0));
    check("mid_rst_rsp", 32'(g_dut[0].bus.rsp_valid), 32'(0));
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    g_dut[0].bus.a_data = 4'b0011; g_dut[0].bus.a_cnt = 3'd1; g_dut[0].bus.a_dir = DIR_LEFT;
    g_dut[0].bus.b_data = 4'b0100; g_dut[0].bus.b_cnt = 3'd1; g_dut[0].bus.b_dir = DIR_RIGHT;
    g_dut[0].bus.a_valid = 1'b1;
    g_dut[0].bus.b_valid = 1'b1;
    #1;
    check("post_rst_grant", 32'({g_dut[0].bus.a_ready, g_dut[0].bus.b_ready}), 32'(2'b10));
    @(posedge clk); #1;
    g_dut[0].bus.a_valid = 1'b0;
    wait_any0(ra, rb);
    check("post_rst_then_b", 32'({ra, rb}), 32'(2'b01));
    @(posedge clk); #1;
    g_dut[0].bus.b_valid = 1'b0;
    drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_reg_sequencer.md
Name: shift_reg_sequencer

Overview:
Two-port command sequencer for a shared 4-bit load/shift register. Each command carries a parallel word, a shift count and a direction; a round-robin arbiter grants one requester at a time. The sequencer drives the register's load/shift/dir/data_in lines, paces shifts with a prescaler and returns the register's final contents as a tagged response. It sits between requesting blocks and one shift_register instance in the lab datapath.

Parameters:
W, 4, data width of the controlled shift register
CNT_W, 3, width of shift-count fields; requested counts above W are clamped to W
DIV, 1, clk cycles per shift step (DIV >= 1)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
a_valid  input  1  requester A command valid
a_ready  output  1  requester A command accepted this cycle
a_data  input  W  A parallel load word
a_cnt  input  CNT_W  A shift count
a_dir  input  1  A direction: 1=left (toward MSB, LSB filled 0), 0=right (MSB filled 0)
b_valid, b_ready, b_data, b_cnt, b_dir  same as A, requester B
sr_load  output  1  to shift register load
sr_shift  output  1  to shift register shift
sr_dir  output  1  to shift register dir
sr_data_in  output  W  to shift register data_in
sr_data_out  input  W  from shift register data_out
rsp_valid  output  1  one-cycle response strobe
rsp_id  output  1  0=A, 1=B
rsp_data  output  W  register contents after sequence
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async): state IDLE; all outputs 0; RR pointer favours A. Reset is shared with the shift register, so both clear together.
- FSM states: IDLE -> LOAD -> SHIFT (skipped if count=0) -> CAPTURE -> IDLE.
- IDLE: ready is asserted combinationally only here, to the granted requester only. Grant rules: single valid wins; both valid goes to the RR pointer. Handshake completes when valid&ready in the same cycle. On accept: latch data, min(cnt,W), dir and id; flip pointer to the other requester; next state LOAD. Valid may drop without handshake; no commitment is held.
- LOAD (1 cycle): sr_load=1, sr_data_in=latched data. Next state is CAPTURE if count=0, else SHIFT.
- SHIFT: prescaler counts 0..DIV-1. At DIV-1: sr_shift=1 for one cycle, remaining count decrements, prescaler wraps. After the last shift, next state is CAPTURE. sr_dir=latched dir throughout LOAD and SHIFT.
- sr_load and sr_shift are never asserted together. Outside LOAD, sr_data_in=0.
- CAPTURE (1 cycle): rsp_valid=1, rsp_data=sr_data_out, rsp_id=latched id. No backpressure. Next state IDLE.
- Latency from accept edge to rsp_valid cycle: 2 + n*DIV cycles, n = clamped count. The next command can be accepted in the cycle after CAPTURE.
- Reset mid-operation: sequence aborts, no response, pointer returns to A.
- Same requester re-asserting back-to-back while the other waits: the other wins the next grant.

Optional Feature:
STAT_CNT_EN:
- Defined: adds output op_count[15:0], incremented on each rsp_valid, saturating at 16'hFFFF, cleared by rst.
- Undefined: port and logic are absent.

Decomposition:
- Package shift_seq_pkg holds the state enum (IDLE, LOAD, SHIFT, CAPTURE), DIR_LEFT=1 / DIR_RIGHT=0, and the id encodings REQ_A=0 / REQ_B=1.
- Sub-module rr_arb2: 2-way round-robin grant with pointer update on accept.

Test Plan:
- A: data=1011, cnt=1, dir=1, DIV=1 -> rsp_valid 3 cycles after accept, rsp_data=0110, rsp_id=0.
- B: data=1011, cnt=2, dir=0 -> rsp_data=0010, rsp_id=1; exactly 2 sr_shift pulses, sr_dir=0.
- A and B valid in the same cycle after reset (A=0001, B=1000, cnt=0) -> A served first (rsp 0001, id 0), then B (rsp 1000, id 1); each completes 2 cycles after accept.
- cnt=7, data=1111, dir=1 -> clamped to 4 shifts; rsp_data=0000; busy high for 6 cycles.
- DIV=3, cnt=2 -> sr_shift pulses 3 cycles apart; rsp 8 cycles after accept.
- rst asserted during SHIFT -> all outputs 0 immediately, no rsp_valid; the next simultaneous request is granted to A.
